plot_framebuffer: RTL

PLOT_FRAMEBUFFER -- requirements
Module: plot_framebuffer

---
 rtl/pong_pkg.sv | 19 +
 rtl/fb_ram.sv | 35 +++
 rtl/plot_framebuffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module : pong_pkg
// Shared pong video constants: default frame size and framebuffer FSM states.
// Rev    : 1.0
// ============================================================================
package pong_pkg;

  localparam logic [8:0] DEF_SCREEN_WIDTH  = 9'd160;
  localparam logic [8:0] DEF_SCREEN_HEIGHT = 9'd120;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;

  typedef logic [2:0] colour_t;

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module : fb_ram
// Simple dual-port pixel store: one write port, one registered read port.
// Rev    : 1.0
// ============================================================================
module fb_ram
  import pong_pkg::*;
#(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  colour_t           i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output colour_t           o_rdata
);

  colour_t mem_q [DEPTH];
  colour_t rdata_q;

  // No reset on the array or read register so synthesis can map it to block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/plot_framebuffer.sv
`default_nettype none
// ============================================================================
// Module : plot_framebuffer
// Pixel framebuffer with plot writes, full-frame clear and a valid/ready scan-out.
// Rev    : 1.0
// ============================================================================
module plot_framebuffer
  import pong_pkg::*;
#(
  parameter logic [8:0] SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter logic [8:0] SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] colour,
  input  logic       clear_start,
  input  logic [2:0] clear_color,
  input  logic       scan_start,
  input  logic       m_ready,
  output logic       m_valid,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_color,
  output logic       m_last,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int             DEPTH     = int'(SCREEN_WIDTH) * int'(SCREEN_HEIGHT);
  localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [7:0]     X_MAX     = 8'(SCREEN_WIDTH - 9'd1);
  localparam logic [6:0]     Y_MAX     = 7'(SCREEN_HEIGHT - 9'd1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  colour_t       clr_color_q, clr_color_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]    rd_x_q, rd_x_d;
  logic [6:0]    rd_y_q, rd_y_d;
  logic          rd_more_q, rd_more_d;
  logic          p_valid_q, p_valid_d;
  logic [AW-1:0] p_addr_q, p_addr_d;
  logic [7:0]    p_x_q, p_x_d;
  logic [6:0]    p_y_q, p_y_d;
  logic          byp_hit_q, byp_hit_d;
  colour_t       byp_data_q, byp_data_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    out_x_q, out_x_d;
  logic [6:0]    out_y_q, out_y_d;
  colour_t       out_color_q, out_color_d;
  logic          m_last_q, m_last_d;
  logic [7:0]    drop_q, drop_d;

  logic          w_in_range, w_plot_we, w_drop;
  logic [AW-1:0] w_plot_addr;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_waddr, w_raddr;
  colour_t       w_ram_wdata, w_rdata, w_fetch_color;
  logic          w_start_scan, w_load, w_advance, w_issue, w_iss_last;
  logic [AW-1:0] w_iss_addr;
  logic [7:0]    w_iss_x;
  logic [6:0]    w_iss_y;

  assign w_in_range  = ({1'b0, vga_x} < SCREEN_WIDTH) && ({2'b00, vga_y} < SCREEN_HEIGHT);
  assign w_plot_addr = AW'(int'(vga_y) * int'(SCREEN_WIDTH) + int'(vga_x));
  assign w_plot_we   = plot && w_in_range && (state_q != ST_CLEAR);
  assign w_drop      = plot && (!w_in_range || (state_q == ST_CLEAR));

  assign w_ram_we    = (state_q == ST_CLEAR) || w_plot_we;
  assign w_ram_waddr = (state_q == ST_CLEAR) ? clr_addr_q  : w_plot_addr;
  assign w_ram_wdata = (state_q == ST_CLEAR) ? clr_color_q : colour;

  // Fetch stage holds one prefetched pixel; it re-reads the same address while stalled.
  assign w_start_scan = (state_q == ST_IDLE) && scan_start && !clear_start;
  assign w_load       = (state_q == ST_SCAN) && p_valid_q && (!m_valid_q || m_ready);
  assign w_advance    = !p_valid_q || w_load;
  assign w_issue      = w_start_scan || ((state_q == ST_SCAN) && w_advance && rd_more_q);
  assign w_iss_addr   = w_start_scan ? '0 : rd_addr_q;
  assign w_iss_x      = w_start_scan ? '0 : rd_x_q;
  assign w_iss_y      = w_start_scan ? '0 : rd_y_q;
  assign w_iss_last   = (w_iss_x == X_MAX) && (w_iss_y == Y_MAX);
  assign w_raddr      = w_issue ? w_iss_addr : p_addr_q;

  // A write landing on the fetched address, now or in the read cycle, wins over RAM data.
  assign w_fetch_color = (w_ram_we && (w_ram_waddr == p_addr_q)) ? w_ram_wdata :
                         byp_hit_q ? byp_data_q : w_rdata;
  assign byp_hit_d     = w_ram_we && (w_ram_waddr == w_raddr);
  assign byp_data_d    = w_ram_wdata;

  fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_fb_ram (
    .clk     (clock),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    rd_addr_d   = rd_addr_q;
    rd_x_d      = rd_x_q;
    rd_y_d      = rd_y_q;
    rd_more_d   = rd_more_q;
    p_valid_d   = p_valid_q;
    p_addr_d    = p_addr_q;
    p_x_d       = p_x_q;
    p_y_d       = p_y_q;
    m_valid_d   = m_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_color_d = out_color_q;
    m_last_d    = m_last_q;
    drop_d      = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
        end else if (scan_start) begin
          state_d = ST_SCAN;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_issue) begin
      p_valid_d = 1'b1;
      p_addr_d  = w_iss_addr;
      p_x_d     = w_iss_x;
      p_y_d     = w_iss_y;
      rd_more_d = !w_iss_last;
      rd_addr_d = w_iss_addr + AW'(1);
      if (w_iss_x == X_MAX) begin
        rd_x_d = '0;
        rd_y_d = w_iss_y + 7'd1;
      end else begin
        rd_x_d = w_iss_x + 8'd1;
        rd_y_d = w_iss_y;
      end
    end else if (w_load) begin
      p_valid_d = 1'b0;
    end

    if (w_load) begin
      m_valid_d   = 1'b1;
      out_x_d     = p_x_q;
      out_y_d     = p_y_q;
      out_color_d = w_fetch_color;
      m_last_d    = (p_x_q == X_MAX) && (p_y_q == Y_MAX);
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (w_drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      rd_addr_q   <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      rd_more_q   <= 1'b0;
      p_valid_q   <= 1'b0;
      p_addr_q    <= '0;
      p_x_q       <= '0;
      p_y_q       <= '0;
      byp_hit_q   <= 1'b0;
      byp_data_q  <= '0;
      m_valid_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_color_q <= '0;
      m_last_q    <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      rd_addr_q   <= rd_addr_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      rd_more_q   <= rd_more_d;
      p_valid_q   <= p_valid_d;
      p_addr_q    <= p_addr_d;
      p_x_q       <= p_x_d;
      p_y_q       <= p_y_d;
      byp_hit_q   <= byp_hit_d;
      byp_data_q  <= byp_data_d;
      m_valid_q   <= m_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_color_q <= out_color_d;
      m_last_q    <= m_last_d;
      drop_q      <= drop_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_color  = out_color_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign drop_count = drop_q;

endmodule
`default_nettype wire
